// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//   Sits directly after the combinational multiplier. Takes one product per
//   valid/ready handshake, sums p_count of them into a dot-product result
//   and holds that result on a valid/ready output until the consumer takes it.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   ACC   | collecting products; o_w_acc shows the running partial sum
//   DONE  | final sum presented on o_w_acc, waiting for i_w_ready
//
// Build option:
//   PRODUCT_ACCUMULATOR_SATURATE_EN  defined   -> sum clamps to all-ones and
//                                                  o_w_ovf is set (sticky)
//                                    undefined -> sum wraps, o_w_ovf = 0
//
// Ports:
//   i_w_clk, i_w_rst_n   clock (rising edge), async active-low reset
//   i_w_clear            sync clear, aborts the sum and drops a pending result
//   i_w_p, i_w_valid     product input and its valid
//   o_w_ready            product accepted when i_w_valid && o_w_ready
//   o_w_acc              running sum in ACC, final result in DONE
//   o_w_count            products accepted into the current sum
//   o_w_valid, i_w_ready result handshake
//   o_w_ovf              sum saturated (saturating build only)
// ---------------------------------------------------------------------------
module product_accumulator #(
    parameter int p_width     = 4,
    parameter int p_count     = 4,
    parameter int p_acc_width = 10,
    localparam int p_cw       = (p_count > 1) ? $clog2(p_count) : 1
) (
    input  logic                   i_w_clk,
    input  logic                   i_w_rst_n,
    input  logic                   i_w_clear,
    input  logic [2*p_width-1:0]   i_w_p,
    input  logic                   i_w_valid,
    output logic                   o_w_ready,
    output logic [p_acc_width-1:0] o_w_acc,
    output logic [p_cw-1:0]        o_w_count,
    output logic                   o_w_valid,
    input  logic                   i_w_ready,
    output logic                   o_w_ovf
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [p_cw-1:0] LAST = p_cw'(p_count - 1);

    state_t                 state_q;
    logic [p_acc_width-1:0] acc_q;
    logic [p_acc_width-1:0] acc_d;
    logic [p_cw-1:0]        count_q;
    logic                   ovf_d;
    logic                   accept;

    // i_w_clear pulls ready low so a product presented alongside a clear
    // is never counted as accepted by the upstream stage.
    assign o_w_ready = (state_q == ST_ACC) && !i_w_clear;
    assign accept    = o_w_ready && i_w_valid;
    assign o_w_valid = (state_q == ST_DONE);
    assign o_w_acc   = acc_q;
    assign o_w_count = count_q;

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    localparam int p_sw = p_acc_width + 1;

    logic            ovf_q;
    logic [p_sw-1:0] sum_full;

    // One extra bit catches the carry out; once saturated the accumulator is
    // all-ones, so any further non-zero add carries again and stays clamped.
    always_comb begin
        sum_full = {1'b0, acc_q} + p_sw'(i_w_p);
        acc_d    = sum_full[p_acc_width-1:0];
        ovf_d    = ovf_q;
        if (sum_full[p_acc_width]) begin
            acc_d = '1;
            ovf_d = 1'b1;
        end
    end

    assign o_w_ovf = ovf_q;
`else
    always_comb begin
        acc_d = acc_q + p_acc_width'(i_w_p);
        ovf_d = 1'b0;
    end

    assign o_w_ovf = 1'b0;
`endif

    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            count_q <= '0;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
            ovf_q   <= 1'b0;
`endif
        end else if (i_w_clear) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            count_q <= '0;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        acc_q <= acc_d;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
                        ovf_q <= ovf_d;
`endif
                        if (count_q == LAST) begin
                            count_q <= '0;
                            state_q <= ST_DONE;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (i_w_ready) begin
                        state_q <= ST_ACC;
                        acc_q   <= '0;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
                        ovf_q   <= 1'b0;
`endif
                    end
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

`ifndef PRODUCT_ACCUMULATOR_SATURATE_EN
    // ovf_d only carries meaning in the saturating build.
    logic unused_ovf;
    assign unused_ovf = ovf_d;
`endif

endmodule
